// File: rtl/iter_alu_if.sv
// Request/response handshake bundle for the iterative ALU.
// The master drives requests and consumes results; the slave is the ALU.
interface iter_alu_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result_lo;
    logic [W-1:0] result_hi;
    logic         zero;
    logic         div_by_zero;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result_lo, result_hi,
        input  zero, div_by_zero
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result_lo, result_hi,
        output zero, div_by_zero
    );
endinterface

// File: rtl/iter_alu.sv
// Multi-cycle ALU: single-cycle add/logic/compare ops plus
// shift-add unsigned multiply and restoring unsigned divide.
module iter_alu #(
    parameter int W = 32
) (
    input logic       clk,
    input logic       rst_n,
    iter_alu_if.slave io
);
    localparam int CW = $clog2(W) + 1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_SLTU = 3'b101;
    localparam logic [2:0] OP_MULU = 3'b110;
    localparam logic [2:0] OP_DIVU = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [W-1:0]  lo;
    logic [W-1:0]  hi;
    logic [W-1:0]  opnd;
    logic [CW-1:0] cnt;
    logic          dbz;
    logic          last;
    logic          slt;
    logic          sltu;
    logic [W-1:0]  sres;
    logic [W:0]    msum;
    logic [W:0]    dtry;
    logic [W:0]    ddif;
    logic          qbit;

    assign last = (cnt == CW'(W - 1));

    assign io.in_ready    = (state == IDLE);
    assign io.out_valid   = (state == DONE);
    assign io.result_lo   = lo;
    assign io.result_hi   = hi;
    assign io.zero        = (lo == '0);
    assign io.div_by_zero = dbz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (io.in_valid) begin
                    if (io.op == OP_MULU) begin
                        state_n = MUL;
                    end else if (io.op == OP_DIVU) begin
                        state_n = DIV;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            MUL: begin
                if (last) state_n = DONE;
            end
            DIV: begin
                if (last) state_n = DONE;
            end
            DONE: begin
                if (io.out_ready) state_n = IDLE;
            end
        endcase
    end

    assign slt  = ($signed(io.a) < $signed(io.b));
    assign sltu = (io.a < io.b);

    always_comb begin
        sres = '0;
        unique case (io.op)
            OP_ADD:  sres = io.a + io.b;
            OP_AND:  sres = io.a & io.b;
            OP_OR:   sres = io.a | io.b;
            OP_SUB:  sres = io.a - io.b;
            OP_SLT:  sres = {{(W-1){1'b0}}, slt};
            OP_SLTU: sres = {{(W-1){1'b0}}, sltu};
            default: sres = '0;
        endcase
    end

    // Multiply: {hi,lo} shifts right, lo starts as the multiplier.
    assign msum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);

    // Divide: lo starts as the dividend and collects quotient bits.
    assign dtry = {hi, lo[W-1]};
    assign ddif = dtry - {1'b0, opnd};
    assign qbit = (dtry >= {1'b0, opnd});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo   <= '0;
            hi   <= '0;
            opnd <= '0;
            cnt  <= '0;
            dbz  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (io.in_valid) begin
                        cnt <= '0;
                        hi  <= '0;
                        dbz <= (io.op == OP_DIVU) && (io.b == '0);
                        if (io.op == OP_MULU) begin
                            opnd <= io.a;
                            lo   <= io.b;
                        end else if (io.op == OP_DIVU) begin
                            opnd <= io.b;
                            lo   <= io.a;
                        end else begin
                            lo   <= sres;
                        end
                    end
                end
                MUL: begin
                    hi  <= msum[W:1];
                    lo  <= {msum[0], lo[W-1:1]};
                    cnt <= cnt + CW'(1);
                end
                DIV: begin
                    hi  <= qbit ? ddif[W-1:0] : dtry[W-1:0];
                    lo  <= {lo[W-2:0], qbit};
                    cnt <= cnt + CW'(1);
                end
                DONE: begin
                end
            endcase
        end
    end
endmodule
